// File: rtl/alu_mdu.sv
// EX-stage ALU: single-cycle combinational ops plus an iterative unsigned multiply/divide unit writing HI/LO.
// Optional macro ALU_OVF_EN adds the ALU_Ovf signed-overflow output for ADD/SUB.
module alu_mdu #(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ALU_DA,
    input  logic [WIDTH-1:0] ALU_DB,
    input  logic [3:0]       ALUOp,
    input  logic             ALU_Start,
    output logic [WIDTH-1:0] ALU_DC,
    output logic             ALU_Zero,
`ifdef ALU_OVF_EN
    output logic             ALU_Ovf,
`endif
    output logic             ALU_Busy,
    output logic             ALU_Done
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_NOR   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_MFLO  = 4'b1111;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic             w_launch;
    logic             w_finish;
    logic [SHW-1:0]   r_cnt;
    logic             r_div;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_wh;
    logic [WIDTH-1:0] r_wl;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH:0]   w_msum;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_wh_nx;
    logic [WIDTH-1:0] w_wl_nx;

    assign w_add   = ALU_DA + ALU_DB;
    assign w_sub   = ALU_DA - ALU_DB;
    assign w_shamt = ALU_DA[SHW-1:0];

    // Combinational result path; every opcode drives a value
    always_comb begin
        ALU_DC = '0;
        case (ALUOp)
            OP_ADD:  ALU_DC = w_add;
            OP_SUB:  ALU_DC = w_sub;
            OP_AND:  ALU_DC = ALU_DA & ALU_DB;
            OP_NOR:  ALU_DC = ~(ALU_DA | ALU_DB);
            OP_OR:   ALU_DC = ALU_DA | ALU_DB;
            OP_XOR:  ALU_DC = ALU_DA ^ ALU_DB;
            OP_SLT:  ALU_DC = WIDTH'($signed(ALU_DA) < $signed(ALU_DB));
            OP_SLTU: ALU_DC = WIDTH'(ALU_DA < ALU_DB);
            OP_SLL:  ALU_DC = ALU_DB << w_shamt;
            OP_SRL:  ALU_DC = ALU_DB >> w_shamt;
            OP_SRA:  ALU_DC = WIDTH'($signed(ALU_DB) >>> w_shamt);
            OP_MFHI: ALU_DC = r_hi;
            OP_MFLO: ALU_DC = r_lo;
            default: ALU_DC = '0;
        endcase
    end

    assign ALU_Zero = (ALU_DC == '0);

`ifdef ALU_OVF_EN
    always_comb begin
        ALU_Ovf = 1'b0;
        if (ALUOp == OP_ADD)
            ALU_Ovf = (ALU_DA[WIDTH-1] == ALU_DB[WIDTH-1]) && (w_add[WIDTH-1] != ALU_DA[WIDTH-1]);
        else if (ALUOp == OP_SUB)
            ALU_Ovf = (ALU_DA[WIDTH-1] != ALU_DB[WIDTH-1]) && (w_sub[WIDTH-1] != ALU_DA[WIDTH-1]);
    end
`endif

    // One MDU step: r_wh holds accumulator/remainder, r_wl multiplier/quotient
    assign w_msum   = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_b} : '0);
    assign w_rem_sh = {r_wh, r_wl[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_b;

    always_comb begin
        w_wh_nx = w_msum[WIDTH:1];
        w_wl_nx = {w_msum[0], r_wl[WIDTH-1:1]};
        if (r_div) begin
            w_wh_nx = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
            w_wl_nx = {r_wl[WIDTH-2:0], w_ge};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_launch   = 1'b0;
        w_finish   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ALU_Start && (ALUOp == OP_MULTU || ALUOp == OP_DIVU)) begin
                    w_launch   = 1'b1;
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == SHW'(WIDTH - 1)) begin
                    w_finish   = 1'b1;
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_div  <= 1'b0;
            r_b    <= '0;
            r_wh   <= '0;
            r_wl   <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_launch) begin
                r_cnt <= '0;
                r_div <= ALUOp[0];
                r_b   <= ALU_DB;
                r_wh  <= '0;
                r_wl  <= ALU_DA;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt + SHW'(1);
                r_wh  <= w_wh_nx;
                r_wl  <= w_wl_nx;
            end
            // Divide by zero falls out naturally: quotient all ones, remainder = dividend
            if (w_finish) begin
                r_hi <= w_wh_nx;
                r_lo <= w_wl_nx;
            end
        end
    end

    assign ALU_Busy = (r_state == ST_RUN);
    assign ALU_Done = r_done;

endmodule

// File: tb/tb_alu_mdu.sv
// Randomized self-checking bench for alu_mdu against an arithmetic reference model.
module tb_alu_mdu;

    localparam int unsigned W = 32;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_SLT = 4'd6,  OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd10, OP_RSV = 4'd11, OP_MULTU = 4'd12, OP_DIVU = 4'd13;
    localparam logic [3:0] OP_MFHI = 4'd14, OP_MFLO = 4'd15;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] da, db, dc;
    logic [3:0]   op;
    logic         start, zero, busy, done;
`ifdef ALU_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] m_hi, m_lo;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .ALU_DA(da), .ALU_DB(db), .ALUOp(op), .ALU_Start(start),
        .ALU_DC(dc), .ALU_Zero(zero),
`ifdef ALU_OVF_EN
        .ALU_Ovf(ovf),
`endif
        .ALU_Busy(busy), .ALU_Done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] pw;
        int unsigned    sh;
        sh = a % W;
        pw = (2*W)'(1) << sh;
        case (o)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return ~(a | b);
            4'd4:  return a | b;
            4'd5:  return a ^ b;
            4'd6:  return (a[W-1] != b[W-1]) ? W'(a[W-1]) : W'(a < b);
            4'd7:  return W'(a < b);
            4'd8:  return W'({{W{1'b0}}, b} * pw);
            4'd9:  return W'({{W{1'b0}}, b} / pw);
            4'd10: return b[W-1] ? ~W'({{W{1'b0}}, ~b} / pw) : W'({{W{1'b0}}, b} / pw);
            4'd14: return m_hi;
            4'd15: return m_lo;
            default: return '0;
        endcase
    endfunction

`ifdef ALU_OVF_EN
    function automatic logic ref_ovf(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = (o == 4'd0) ? sa + sb : sa - sb;
        if (o > 4'd1) return 1'b0;
        return (r > longint'(2**(W-1) - 1)) || (r < -longint'(2**(W-1)));
    endfunction
`endif

    task automatic check_comb(input string tag);
        check({tag, "_dc"}, 64'(dc), 64'(ref_alu(op, da, db)));
        check({tag, "_zero"}, 64'(zero), 64'(ref_alu(op, da, db) == '0));
`ifdef ALU_OVF_EN
        check({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf(op, da, db)));
`endif
    endtask

    task automatic apply(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input string tag);
        op = o; da = a; db = b;
        #1;
        check(tag, 64'(dc), 64'(exp));
        check_comb(tag);
    endtask

    // Launch an MDU op from the current cycle; returns in the Done cycle
    task automatic run_mdu(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        op = o; da = a; db = b; start = 1'b1;
        for (int i = 1; i <= W; i++) begin
            tick();
            start = 1'b0;
            da = W'($urandom);
            db = W'($urandom);
            op = 4'($urandom_range(0, 11));
            if (i == W/2) begin
                start = 1'b1;
                op    = OP_DIVU;
            end
            if (i == 3) op = OP_MFHI;
            #1;
            check("busy_run", 64'(busy), 64'd1);
            check("done_run", 64'(done), 64'd0);
            if (i == 3) check("mfhi_during_run", 64'(dc), 64'(m_hi));
        end
        if (o == OP_MULTU) begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            m_hi = p[2*W-1:W];
            m_lo = p[W-1:0];
        end else if (b == '0) begin
            m_lo = '1;
            m_hi = a;
        end else begin
            m_lo = a / b;
            m_hi = a % b;
        end
        tick();
        start = 1'b0;
        op = OP_MFHI;
        #1;
        check("busy_end", 64'(busy), 64'd0);
        check("done_pulse", 64'(done), 64'd1);
        check("mfhi", 64'(dc), 64'(m_hi));
        op = OP_MFLO;
        #1;
        check("mflo", 64'(dc), 64'(m_lo));
    endtask

    initial begin
        m_hi = '0; m_lo = '0;
        reset = 1'b1; start = 1'b0; op = OP_ADD; da = '0; db = '0;
        tick(); tick();
        reset = 1'b0;
        op = OP_MFHI;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mfhi", 64'(dc), 64'd0);
        check("rst_zero", 64'(zero), 64'd1);

        apply(OP_SUB,  32'd5, 32'd5, 32'd0, "sub_eq");
        check("sub_zero", 64'(zero), 64'd1);
        apply(OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, "slt");
        apply(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");
        apply(OP_SRA,  32'd4, 32'h8000_0000, 32'hF800_0000, "sra");
        apply(OP_RSV,  32'h1234, 32'h5678, 32'd0, "rsv");
        apply(OP_ADD,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000, "add_wrap");
        apply(OP_SUB,  32'h8000_0000, 32'd1, 32'h7FFF_FFFF, "sub_wrap");
        apply(OP_ADD,  32'd1, 32'd1, 32'd2, "add_small");

        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            da = (i % 4 == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            db = (i % 5 == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            if (i % 7 == 0) db = {1'b1, W'($urandom) >> 1};
            #1;
            check_comb("rand_comb");
            tick();
        end

        run_mdu(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        check("mul_hi_const", 64'(m_hi), 64'h1);
        run_mdu(OP_DIVU, 32'd100, 32'd7);
        run_mdu(OP_DIVU, 32'h1234, 32'd0);
        for (int k = 0; k < 12; k++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = (k % 3 == 0) ? W'($urandom_range(0, 9)) : W'($urandom);
            if (k % 4 == 0) b = '0;
            run_mdu((k % 2 == 0) ? OP_MULTU : OP_DIVU, a, b);
        end

        // Reset in RUN cycle 10 aborts the op without writing HI/LO
        op = OP_MULTU; da = 32'hDEAD_BEEF; db = 32'h1234_5678; start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            start = 1'b0;
        end
        check("busy_pre_rst", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        op = OP_MFHI;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_hi", 64'(dc), 64'd0);
        op = OP_MFLO;
        #1;
        check("rst_mid_lo", 64'(dc), 64'd0);
        for (int i = 0; i < W + 3; i++) begin
            tick();
            check("no_done_after_rst", 64'(done | busy), 64'd0);
        end

        run_mdu(OP_DIVU, 32'hFFFF_FFFF, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
